// File: rtl/spq_dequeue_reader.sv
// spq_dequeue_reader: SPQueue consumer-side dequeue controller with 2-entry output buffer; SPQ_READER_STATS_EN adds deq_total/stall_cycles counters
module spq_dequeue_reader #(
    parameter int DW     = 8,
    parameter int QDEPTH = 8,
    parameter int RD_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enq_seen,
    input  logic [DW-1:0]                q_data,
    output logic                         deq_sig,
    output logic [DW-1:0]                m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(QDEPTH+1)-1:0]  occupancy,
    output logic                         q_empty,
    output logic                         enq_drop
`ifdef SPQ_READER_STATS_EN
    ,
    output logic [15:0]                  deq_total,
    output logic [15:0]                  stall_cycles
`endif
);
    localparam int OW = $clog2(QDEPTH + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, CAP} state_t;
    state_t          state_q, state_d;
    logic [2:0]      wcnt_q, wcnt_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            drop_q, drop_d, deq_q, deq_d;
    logic [DW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            push, pop;
    assign push = state_q == CAP;
    assign pop  = m_valid && m_ready;
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: state_d = (occ_q != '0 && cnt_q < 2'd2) ? REQ : IDLE;
            REQ: begin
                state_d = (RD_LAT == 1) ? CAP : WAIT;
                wcnt_d  = '0;
            end
            WAIT: begin
                wcnt_d  = wcnt_q + 3'd1;
                state_d = (wcnt_q == 3'(RD_LAT - 2)) ? CAP : WAIT;
            end
            default: state_d = IDLE;
        endcase
        deq_d  = state_d == REQ;
        occ_d  = (enq_seen && !deq_q) ? ((occ_q == OW'(QDEPTH)) ? occ_q : occ_q + OW'(1))
               : (!enq_seen && deq_q) ? occ_q - OW'(1) : occ_q;
        drop_d = drop_q || (enq_seen && !deq_q && occ_q == OW'(QDEPTH));
        // head refills from tail on a pop, or directly from the queue when it would otherwise be empty
        head_d = (pop && cnt_q == 2'd2) ? tail_q
               : (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? q_data : head_q;
        tail_d = (push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop))) ? q_data : tail_q;
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            occ_q   <= '0;
            drop_q  <= 1'b0;
            deq_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            occ_q   <= occ_d;
            drop_q  <= drop_d;
            deq_q   <= deq_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end
    assign deq_sig   = deq_q;
    assign m_data    = head_q;
    assign m_valid   = cnt_q != 2'd0;
    assign occupancy = occ_q;
    assign q_empty   = occ_q == '0;
    assign enq_drop  = drop_q;
`ifdef SPQ_READER_STATS_EN
    logic [15:0] tot_q, stall_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            tot_q   <= '0;
            stall_q <= '0;
        end else begin
            if (pop && tot_q != 16'hFFFF) tot_q <= tot_q + 16'd1;
            if (m_valid && !m_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end
    assign deq_total    = tot_q;
    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_spq_dequeue_reader.sv
// tb_spq_dequeue_reader: directed bench for spq_dequeue_reader (RD_LAT=1 and RD_LAT=3 instances)
module tb_spq_dequeue_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst1, enq1, deq1, mv1, mr1, qe1, drop1;
    logic [7:0] qd1 = 8'd0, md1;
    logic [3:0] occ1;
    logic rst3, enq3, deq3, mv3, mr3, qe3, drop3;
    logic [7:0] qd3 = 8'hA5, md3;
    logic [3:0] occ3;
`ifdef SPQ_READER_STATS_EN
    logic [15:0] tot1, stall1, tot3, stall3;
`endif
    int tests = 0, fails = 0, pulses1 = 0, dc = 0;
    logic [7:0] vals [16];
    spq_dequeue_reader #(.DW(8), .QDEPTH(8), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst1), .enq_seen(enq1), .q_data(qd1), .deq_sig(deq1),
        .m_data(md1), .m_valid(mv1), .m_ready(mr1), .occupancy(occ1),
        .q_empty(qe1), .enq_drop(drop1)
`ifdef SPQ_READER_STATS_EN
        , .deq_total(tot1), .stall_cycles(stall1)
`endif
    );
    spq_dequeue_reader #(.DW(8), .QDEPTH(8), .RD_LAT(3)) u3 (
        .clk(clk), .rst(rst3), .enq_seen(enq3), .q_data(qd3), .deq_sig(deq3),
        .m_data(md3), .m_valid(mv3), .m_ready(mr3), .occupancy(occ3),
        .q_empty(qe3), .enq_drop(drop3)
`ifdef SPQ_READER_STATS_EN
        , .deq_total(tot3), .stall_cycles(stall3)
`endif
    );
    // queue model for u1: data_out presents the next entry one cycle after each dequeue pulse
    always @(posedge clk) begin
        if (deq1) begin
            qd1 <= vals[dc % 16];
            dc  <= dc + 1;
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
        if (deq1) pulses1++;
    endtask
    task automatic test_reset;
        int bad;
        rst1 = 1; rst3 = 1; enq1 = 0; enq3 = 0; mr1 = 0; mr3 = 0;
        tick; tick;
        rst1 = 0; rst3 = 0;
        tests++; if (deq1 !== 1'b0 || mv1 !== 1'b0) begin fails++; $display("FAIL reset_deq_valid: deq=%b valid=%b expected 0 0", deq1, mv1); end
        tests++; if (occ1 !== 4'd0 || qe1 !== 1'b1) begin fails++; $display("FAIL reset_occ: occ=%0d empty=%b expected 0 1", occ1, qe1); end
        tests++; if (md1 !== 8'd0 || drop1 !== 1'b0) begin fails++; $display("FAIL reset_data_drop: data=%0d drop=%b expected 0 0", md1, drop1); end
        tests++; if (mv3 !== 1'b0 || occ3 !== 4'd0 || deq3 !== 1'b0) begin fails++; $display("FAIL reset_u3: valid=%b occ=%0d deq=%b expected 0 0 0", mv3, occ3, deq3); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (deq1 || mv1 || !qe1 || occ1 != 4'd0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL idle_quiet: %0d bad cycles expected 0", bad); end
    endtask
    task automatic test_single;
        int t;
        pulses1 = 0;
        enq1 = 1; tick; enq1 = 0;
        t = 0;
        while (!deq1 && t < 10) begin tick; t++; end
        tests++; if (deq1 !== 1'b1) begin fails++; $display("FAIL single_deq: deq=%b expected 1", deq1); end
        tick;
        tests++; if (mv1 !== 1'b0) begin fails++; $display("FAIL single_early_valid: valid=%b expected 0", mv1); end
        tick;
        tests++; if (mv1 !== 1'b1 || md1 !== 8'd2) begin fails++; $display("FAIL single_data: valid=%b data=%0d expected 1 2", mv1, md1); end
        tests++; if (pulses1 !== 1) begin fails++; $display("FAIL single_pulses: %0d expected 1", pulses1); end
        mr1 = 1; tick; mr1 = 0;
        tests++; if (mv1 !== 1'b0 || occ1 !== 4'd0 || qe1 !== 1'b1) begin fails++; $display("FAIL single_drain: valid=%b occ=%0d empty=%b expected 0 0 1", mv1, occ1, qe1); end
    endtask
    task automatic test_backpressure;
        logic [7:0] exp_v [4];
        int got, t;
        exp_v[0] = 8'd2; exp_v[1] = 8'd2; exp_v[2] = 8'd8; exp_v[3] = 8'd10;
        pulses1 = 0; mr1 = 0;
        enq1 = 1; repeat (4) tick; enq1 = 0;
        repeat (20) tick;
        tests++; if (pulses1 !== 2) begin fails++; $display("FAIL bp_pulses: %0d expected 2", pulses1); end
        tests++; if (mv1 !== 1'b1 || md1 !== 8'd2) begin fails++; $display("FAIL bp_hold: valid=%b data=%0d expected 1 2", mv1, md1); end
        tests++; if (occ1 !== 4'd2) begin fails++; $display("FAIL bp_occ: %0d expected 2", occ1); end
        mr1 = 1; got = 0; t = 0;
        while (got < 4 && t < 60) begin
            if (mv1) begin
                tests++; if (md1 !== exp_v[got]) begin fails++; $display("FAIL bp_order[%0d]: got %0d expected %0d", got, md1, exp_v[got]); end
                got++;
            end
            tick; t++;
        end
        mr1 = 0;
        tests++; if (got !== 4 || pulses1 !== 4) begin fails++; $display("FAIL bp_total: items=%0d pulses=%0d expected 4 4", got, pulses1); end
        tests++; if (occ1 !== 4'd0 || mv1 !== 1'b0) begin fails++; $display("FAIL bp_drain: occ=%0d valid=%b expected 0 0", occ1, mv1); end
    endtask
    task automatic test_simultaneous;
        int t;
        mr1 = 0;
        enq1 = 1; repeat (5) tick; enq1 = 0;
        repeat (12) tick;
        tests++; if (occ1 !== 4'd3) begin fails++; $display("FAIL sim_pre_occ: %0d expected 3", occ1); end
        mr1 = 1; tick; mr1 = 0;
        t = 0;
        while (!deq1 && t < 10) begin tick; t++; end
        tests++; if (deq1 !== 1'b1 || occ1 !== 4'd3) begin fails++; $display("FAIL sim_deq: deq=%b occ=%0d expected 1 3", deq1, occ1); end
        enq1 = 1; tick; enq1 = 0;
        tests++; if (occ1 !== 4'd3) begin fails++; $display("FAIL sim_occ: %0d expected 3", occ1); end
        tick;
        tests++; if (mv1 !== 1'b1 || md1 !== 8'h26) begin fails++; $display("FAIL sim_head: valid=%b data=%h expected 1 26", mv1, md1); end
    endtask
    task automatic test_overflow;
        rst1 = 1; tick; tick; rst1 = 0;
        mr1 = 0;
        enq1 = 1; repeat (10) tick;
        tests++; if (occ1 !== 4'd8 || drop1 !== 1'b0) begin fails++; $display("FAIL ovf_full: occ=%0d drop=%b expected 8 0", occ1, drop1); end
        tick; enq1 = 0;
        tests++; if (occ1 !== 4'd8 || drop1 !== 1'b1) begin fails++; $display("FAIL ovf_drop: occ=%0d drop=%b expected 8 1", occ1, drop1); end
        repeat (5) tick;
        tests++; if (occ1 !== 4'd8 || drop1 !== 1'b1) begin fails++; $display("FAIL ovf_hold: occ=%0d drop=%b expected 8 1", occ1, drop1); end
        mr1 = 1; repeat (40) tick; mr1 = 0;
        tests++; if (occ1 !== 4'd0 || qe1 !== 1'b1 || drop1 !== 1'b1) begin fails++; $display("FAIL ovf_sticky: occ=%0d empty=%b drop=%b expected 0 1 1", occ1, qe1, drop1); end
        rst1 = 1; tick; rst1 = 0;
        tests++; if (drop1 !== 1'b0) begin fails++; $display("FAIL ovf_clear: drop=%b expected 0", drop1); end
    endtask
    task automatic test_reset_mid;
        int t, n, bad;
        enq3 = 1; tick; enq3 = 0;
        t = 0;
        while (!deq3 && t < 10) begin tick; t++; end
        tests++; if (deq3 !== 1'b1) begin fails++; $display("FAIL mid_deq: deq=%b expected 1", deq3); end
        tick;
        rst3 = 1; tick; rst3 = 0;
        tests++; if (mv3 !== 1'b0 || occ3 !== 4'd0 || deq3 !== 1'b0) begin fails++; $display("FAIL mid_reset: valid=%b occ=%0d deq=%b expected 0 0 0", mv3, occ3, deq3); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (mv3 || deq3) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL mid_no_capture: %0d bad cycles expected 0", bad); end
        enq3 = 1; tick; enq3 = 0;
        t = 0;
        while (!deq3 && t < 10) begin tick; t++; end
        n = 0;
        while (!mv3 && n < 10) begin tick; n++; end
        tests++; if (n !== 4 || md3 !== 8'hA5) begin fails++; $display("FAIL mid_clean: latency=%0d data=%h expected 4 a5", n, md3); end
        mr3 = 1; tick; mr3 = 0;
        tests++; if (mv3 !== 1'b0 || occ3 !== 4'd0) begin fails++; $display("FAIL mid_drain: valid=%b occ=%0d expected 0 0", mv3, occ3); end
    endtask
    initial begin
        for (int i = 0; i < 16; i++) vals[i] = 8'(8'h20 + i);
        vals[0] = 8'd2; vals[1] = 8'd2; vals[2] = 8'd2; vals[3] = 8'd8; vals[4] = 8'd10;
        test_reset;
        test_single;
        test_backpressure;
        test_simultaneous;
        test_overflow;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spq_dequeue_reader.md
Name: spq_dequeue_reader

Overview:
- Consumer-side controller for the 8-bit sorted priority queue (SPQueue).
- Mirrors the producer's enqueue pulses to track queue occupancy.
- Issues single-cycle dequeue pulses to the queue, captures its data_out after a fixed read latency, and delivers entries downstream on a valid/ready stream through a 2-entry output buffer.
- Sits between the queue's dequeue port and any downstream consumer, so the consumer never has to drive dequeue_sig directly.

Parameters:
- DW, 8, data width; must match the queue data_in/data_out width.
- QDEPTH, 8, queue capacity used for occupancy tracking.
- RD_LAT, 1, cycles from a dequeue pulse until queue data_out is valid; legal range 1..4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- enq_seen  input  1  copy of the queue's enqueue_sig; one entry added per cycle high.
- q_data  input  DW  queue data_out.
- deq_sig  output  1  dequeue pulse to the queue, registered, exactly one cycle wide per request.
- m_data  output  DW  head of the output buffer.
- m_valid  output  1  m_data is valid.
- m_ready  input  1  downstream accepts; a transfer occurs when m_valid and m_ready are both high.
- occupancy  output  clog2(QDEPTH+1)  tracked queue entries, excluding items already dequeued.
- q_empty  output  1  occupancy == 0.
- enq_drop  output  1  sticky flag: an enqueue was seen while occupancy == QDEPTH; cleared only by rst.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - deq_sig=0, m_valid=0, m_data=0, occupancy=0, q_empty=1, enq_drop=0.
  - Output buffer flushed, FSM forced to IDLE.
  - A dequeue in flight is abandoned; its data is not captured.
- Occupancy update, per cycle:
  - +1 on enq_seen; -1 when deq_sig is high.
  - enq_seen and deq_sig both high in the same cycle: occupancy unchanged.
  - enq_seen with occupancy == QDEPTH and no deq_sig: occupancy stays at QDEPTH and enq_drop is set.
  - Occupancy never underflows; deq_sig is never raised when occupancy == 0.
- FSM states: IDLE, REQ, WAIT, CAP.
  - IDLE -> REQ when occupancy > 0 and buffered count + in-flight count < 2. Otherwise stay in IDLE.
  - REQ: deq_sig=1 for this one cycle. Next state is CAP if RD_LAT == 1, else WAIT.
  - WAIT: count RD_LAT-1 cycles, then go to CAP.
  - CAP: sample q_data on this edge, which is RD_LAT cycles after the deq_sig cycle. Push it into the output buffer, then go to IDLE.
  - At most one dequeue is outstanding at a time.
  - Throughput is one entry per RD_LAT+2 cycles (IDLE, REQ, WAIT cycles, CAP).
- Output buffer: 2-entry FIFO, with m_data/m_valid driven from the head register.
  - First-word latency: deq_sig in cycle T gives m_valid=1 in cycle T+RD_LAT+1.
  - Holding rule: while m_valid=1 and m_ready=0, m_data holds stable.
  - Push and pop in the same cycle keep the count unchanged and preserve ordering.
  - The IDLE->REQ guard guarantees the buffer never overflows; entries arrive in the queue's dequeue order and that order is not altered.
- enq_seen arriving during REQ/WAIT/CAP is counted normally.
- rst asserted mid-WAIT: the next cycle is IDLE with an empty buffer.

Optional Feature:
- Macro: SPQ_READER_STATS_EN.
- Defined:
  - Adds output deq_total (16 bits), incremented on each m_valid&&m_ready transfer and saturating at 16'hFFFF.
  - Adds output stall_cycles (16 bits), incremented while m_valid=1 and m_ready=0, also saturating.
  - Both counters reset to 0 on rst.
- Not defined: neither port exists and there is no counter logic; all other behaviour is identical.

Test Plan:
- Reset then idle: rst high 2 cycles, then enq_seen=0 for 10 cycles -> deq_sig never rises, occupancy=0, q_empty=1, m_valid=0.
- Single item, RD_LAT=1: enq_seen pulse and q_data=8'd2 -> one deq_sig pulse, m_data=2 with m_valid=1 exactly 2 cycles after deq_sig; m_ready=1 clears m_valid; occupancy back to 0.
- Backpressure: 4 enqueues, q_data returns 2,2,8,10 on successive captures, m_ready=0 -> exactly 2 deq_sig pulses, then none; m_data stays 2; occupancy=2. Raise m_ready -> outputs 2,2,8,10 in order, 4 pulses total.
- Simultaneous events: occupancy=3, enq_seen coincides with deq_sig -> occupancy stays 3.
- Overflow: QDEPTH=8 with m_ready=0, 11 enqueues -> occupancy saturates at 8; enq_drop=1 and stays set until rst.
- Reset mid-operation, RD_LAT=3: rst asserted the cycle after deq_sig -> no capture; m_valid=0, occupancy=0; the next enq_seen yields a clean single-item transfer.
